// File: rtl/multicycle_control_fsm.sv
// Multicycle MIPS control unit: Moore FSM sequencing fetch/decode/execute/memory/writeback.
// Optional BNE support is enabled by defining BNE_EN.
module multicycle_control_fsm #(
  parameter int MEM_WAIT = 0,
  parameter int ALUOP_W  = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         opcode,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic               branch_ne,
  output logic               iord,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               mem_to_reg,
  output logic               reg_dst,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [ALUOP_W-1:0] alu_op,
  output logic [1:0]         pc_src,
  output logic               illegal_op,
  output logic [3:0]         state
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,  S_FETCH  = 4'd1,  S_DECODE = 4'd2,  S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,  S_MEMWB  = 4'd5,  S_MEMWR  = 4'd6,  S_EXEC   = 4'd7,
    S_ALUWB  = 4'd8,  S_BRANCH = 4'd9,  S_ADDIEX = 4'd10, S_ADDIWB = 4'd11,
    S_JUMP   = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT);

  state_t     state_q, state_d;
  logic [3:0] wait_q, wait_d;
  logic       last_c;
  logic [1:0] aop_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      wait_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  assign last_c = (wait_q == WAIT_LAST);
  assign state  = state_q;
  assign alu_op = ALUOP_W'(aop_c);

  always_comb begin
    state_d       = state_q;
    wait_d        = 4'd0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    branch_ne     = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    aop_c         = 2'b00;
    pc_src        = 2'b00;
    illegal_op    = 1'b0;
    // Memory-touching states stretch by counting up to MEM_WAIT; counter clears on exit.
    if ((state_q == S_FETCH || state_q == S_MEMRD || state_q == S_MEMWR) && !last_c)
      wait_d = wait_q + 4'd1;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        if (last_c) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        case (opcode)
          OP_RTYPE:     state_d = S_EXEC;
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_BEQ:       state_d = S_BRANCH;
`ifdef BNE_EN
          OP_BNE:       state_d = S_BRANCH;
`endif
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default: begin
            illegal_op = 1'b1;
            state_d    = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        iord     = 1'b1;
        mem_read = 1'b1;
        if (last_c) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
        if (last_c) state_d = S_FETCH;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        aop_c     = 2'b10;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        aop_c         = 2'b01;
        pc_write_cond = 1'b1;
        pc_src        = 2'b01;
`ifdef BNE_EN
        // IR still holds the branch opcode, so it selects the inverted-zero sense.
        branch_ne     = (opcode == OP_BNE);
`endif
        state_d       = S_FETCH;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_JUMP: begin
        pc_write = 1'b1;
        pc_src   = 2'b10;
        state_d  = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: three instances at MEM_WAIT = 0, 2, 3.
module tb_multicycle_control_fsm;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]      rst;
  logic [2:0][5:0] opc;
  logic [2:0]      pw, pwc, bne, iord, mr, mw, irw, m2r, rdst, rw, asa, ill;
  logic [2:0][1:0] asb, aop, psrc;
  logic [2:0][3:0] st;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    multicycle_control_fsm #(.MEM_WAIT(g == 0 ? 0 : g + 1), .ALUOP_W(2)) u_dut (
      .clk(clk), .rst(rst[g]), .opcode(opc[g]),
      .pc_write(pw[g]), .pc_write_cond(pwc[g]), .branch_ne(bne[g]), .iord(iord[g]),
      .mem_read(mr[g]), .mem_write(mw[g]), .ir_write(irw[g]), .mem_to_reg(m2r[g]),
      .reg_dst(rdst[g]), .reg_write(rw[g]), .alu_src_a(asa[g]), .alu_src_b(asb[g]),
      .alu_op(aop[g]), .pc_src(psrc[g]), .illegal_op(ill[g]), .state(st[g])
    );
  end

  // Control word bit positions
  localparam int ILL = 0, PSRC = 1, AOP = 3, ASB = 5, ASA = 7, RW = 8, RDST = 9, M2R = 10,
                 IRW = 11, MW = 12, MR = 13, IORD = 14, BNE = 15, PWC = 16, PW = 17;
  localparam logic [17:0] B1 = 18'd1, B2 = 18'd2, B3 = 18'd3;
  localparam logic [17:0] C_IDLE   = 18'd0;
  localparam logic [17:0] C_FETCH  = (B1 << MR) | (B1 << ASB);
  localparam logic [17:0] C_FETCHL = C_FETCH | (B1 << IRW) | (B1 << PW);
  localparam logic [17:0] C_DEC    = B3 << ASB;
  localparam logic [17:0] C_DECILL = C_DEC | (B1 << ILL);
  localparam logic [17:0] C_MEMADR = (B1 << ASA) | (B2 << ASB);
  localparam logic [17:0] C_MEMRD  = (B1 << IORD) | (B1 << MR);
  localparam logic [17:0] C_MEMWB  = (B1 << RW) | (B1 << M2R);
  localparam logic [17:0] C_MEMWR  = (B1 << IORD) | (B1 << MW);
  localparam logic [17:0] C_EXEC   = (B1 << ASA) | (B2 << AOP);
  localparam logic [17:0] C_ALUWB  = (B1 << RW) | (B1 << RDST);
  localparam logic [17:0] C_BR     = (B1 << ASA) | (B1 << AOP) | (B1 << PWC) | (B1 << PSRC);
  localparam logic [17:0] C_ADDIEX = (B1 << ASA) | (B2 << ASB);
  localparam logic [17:0] C_ADDIWB = B1 << RW;
  localparam logic [17:0] C_JUMP   = (B1 << PW) | (B2 << PSRC);

  int npass = 0, ntotal = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int k, input logic [3:0] est, input logic [17:0] ectl);
    logic [17:0] o;
    o = {pw[k], pwc[k], bne[k], iord[k], mr[k], mw[k], irw[k], m2r[k], rdst[k], rw[k],
         asa[k], asb[k], aop[k], psrc[k], ill[k]};
    ntotal++;
    assert (st[k] === est) npass++;
    else $error("FAIL %s.state inst%0d: observed %0d expected %0d", tag, k, st[k], est);
    ntotal++;
    assert (o === ectl) npass++;
    else $error("FAIL %s.ctl inst%0d: observed %b expected %b", tag, k, o, ectl);
  endtask

  initial begin
    rst = '1;
    opc = '0;
    tick(); tick();
    chk("rst_idle", 0, 4'd0, C_IDLE);
    chk("rst_idle", 1, 4'd0, C_IDLE);
    chk("rst_idle", 2, 4'd0, C_IDLE);

    // MEM_WAIT=0: lw, R, beq, addi, j, illegal, bne
    rst[0] = 1'b0;
    tick(); chk("fetch0", 0, 4'd1, C_FETCHL);
    opc[0] = 6'b100011;
    tick(); chk("lw.dec", 0, 4'd2, C_DEC);
    tick(); chk("lw.adr", 0, 4'd3, C_MEMADR);
    tick(); chk("lw.rd",  0, 4'd4, C_MEMRD);
    tick(); chk("lw.wb",  0, 4'd5, C_MEMWB);
    tick(); chk("lw.end", 0, 4'd1, C_FETCHL);
    opc[0] = 6'b000000;
    tick(); chk("r.dec",  0, 4'd2, C_DEC);
    tick(); chk("r.exec", 0, 4'd7, C_EXEC);
    tick(); chk("r.wb",   0, 4'd8, C_ALUWB);
    tick(); chk("r.end",  0, 4'd1, C_FETCHL);
    opc[0] = 6'b000100;
    tick(); chk("beq.dec", 0, 4'd2, C_DEC);
    tick(); chk("beq.br",  0, 4'd9, C_BR);
    tick(); chk("beq.end", 0, 4'd1, C_FETCHL);
    opc[0] = 6'b001000;
    tick(); chk("addi.dec", 0, 4'd2, C_DEC);
    tick(); chk("addi.ex",  0, 4'd10, C_ADDIEX);
    tick(); chk("addi.wb",  0, 4'd11, C_ADDIWB);
    tick(); chk("addi.end", 0, 4'd1, C_FETCHL);
    opc[0] = 6'b000010;
    tick(); chk("j.dec", 0, 4'd2, C_DEC);
    tick(); chk("j.jmp", 0, 4'd12, C_JUMP);
    tick(); chk("j.end", 0, 4'd1, C_FETCHL);
    opc[0] = 6'b111111;
    tick(); chk("ill.dec", 0, 4'd2, C_DECILL);
    tick(); chk("ill.end", 0, 4'd1, C_FETCHL);
    opc[0] = 6'b000101;
`ifdef BNE_EN
    tick(); chk("bne.dec", 0, 4'd2, C_DEC);
    tick(); chk("bne.br",  0, 4'd9, C_BR | (B1 << BNE));
    tick(); chk("bne.end", 0, 4'd1, C_FETCHL);
`else
    tick(); chk("bne.dec", 0, 4'd2, C_DECILL);
    tick(); chk("bne.end", 0, 4'd1, C_FETCHL);
`endif

    // MEM_WAIT=2: sw takes 3 fetch + decode + memadr + 3 memwr = 8 cycles
    rst[1] = 1'b0;
    tick(); chk("sw2.f0", 1, 4'd1, C_FETCH);
    opc[1] = 6'b101011;
    tick(); chk("sw2.f1",  1, 4'd1, C_FETCH);
    tick(); chk("sw2.f2",  1, 4'd1, C_FETCHL);
    tick(); chk("sw2.dec", 1, 4'd2, C_DEC);
    tick(); chk("sw2.adr", 1, 4'd3, C_MEMADR);
    tick(); chk("sw2.w0",  1, 4'd6, C_MEMWR);
    tick(); chk("sw2.w1",  1, 4'd6, C_MEMWR);
    tick(); chk("sw2.w2",  1, 4'd6, C_MEMWR);
    tick(); chk("sw2.end", 1, 4'd1, C_FETCH);

    // MEM_WAIT=3: reset during the second MEMWR cycle aborts the store
    rst[2] = 1'b0;
    tick(); chk("sw3.f0", 2, 4'd1, C_FETCH);
    opc[2] = 6'b101011;
    tick(); chk("sw3.f1",  2, 4'd1, C_FETCH);
    tick(); chk("sw3.f2",  2, 4'd1, C_FETCH);
    tick(); chk("sw3.f3",  2, 4'd1, C_FETCHL);
    tick(); chk("sw3.dec", 2, 4'd2, C_DEC);
    tick(); chk("sw3.adr", 2, 4'd3, C_MEMADR);
    tick(); chk("sw3.w0",  2, 4'd6, C_MEMWR);
    tick(); chk("sw3.w1",  2, 4'd6, C_MEMWR);
    rst[2] = 1'b1;
    tick(); chk("sw3.rst", 2, 4'd0, C_IDLE);
    rst[2] = 1'b0;
    tick(); chk("sw3.rf0", 2, 4'd1, C_FETCH);
    tick(); chk("sw3.rf1", 2, 4'd1, C_FETCH);
    tick(); chk("sw3.rf2", 2, 4'd1, C_FETCH);
    tick(); chk("sw3.rf3", 2, 4'd1, C_FETCHL);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end
endmodule
